pc_gen: RTL
===========

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_W, default 32, width of all instruction addresses.
REQ-002 Parameter RESET_VEC, default 32'h0, PC value loaded on reset.
REQ-003 Parameter BTB_DEPTH, default 16, number of BTB entries; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rdy  input  1  global ready; low freezes all state.
REQ-007 stall  input  1  fetch stall; high holds pc.
REQ-008 ex_redirect  input  1  execute-stage mispredict redirect.
REQ-009 ex_target  input  ADDR_W  redirect address.
REQ-010 upd_valid  input  1  resolved-branch BTB update strobe.
REQ-011 upd_pc  input  ADDR_W  address of resolved branch.
REQ-012 upd_taken  input  1  resolved direction.
REQ-013 upd_target  input  ADDR_W  resolved taken target.
REQ-014 pc  output  ADDR_W  current fetch address (registered).
REQ-015 pred_taken  output  1  BTB predicts current pc taken (combinational from pc and BTB state).
REQ-016 pred_target  output  ADDR_W  predicted target for current pc; 0 when pred_taken low.

Function
REQ-017 BTB entry SHALL hold valid, tag (ADDR_W-2-IDX_W bits), target (ADDR_W), 2-bit saturating counter; IDX_W = log2(BTB_DEPTH).
REQ-018 Index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]; addr[1:0] ignored.
REQ-019 pred_taken SHALL be high iff indexed entry valid, tag matches pc, and counter[1] = 1.
REQ-020 Next-pc priority per edge: rst -> RESET_VEC; else rdy low -> hold; else ex_redirect -> ex_target; else stall -> hold; else pred_taken -> pred_target; else pc + 4 (modulo 2^ADDR_W, wraps to 0).
REQ-021 ex_redirect SHALL take effect even when stall is high.
REQ-022 Update (upd_valid high, rdy high, rst low), tag hit: counter increments on taken (saturate 3), decrements on not-taken (saturate 0); target overwritten with upd_target when taken.
REQ-023 Update, miss or invalid entry, taken: entry allocated (overwriting any occupant) with valid=1, new tag, upd_target, counter=2'b10.
REQ-024 Update, miss, not-taken: no BTB change.
REQ-025 Lookup in the same cycle as an update to the same index SHALL use pre-update contents; new contents visible the following cycle.
REQ-026 Update and redirect in the same cycle SHALL both complete independently.
REQ-027 Latency: redirect or prediction visible on pc exactly one cycle after the qualifying edge inputs.

Reset
REQ-028 On rst: pc = RESET_VEC, all BTB valid bits = 0, counters = 0; pred_taken = 0 and pred_target = 0 in the following cycle.
REQ-029 rst SHALL override rdy, ex_redirect, stall and upd_valid; reset mid-operation discards pending updates.
REQ-030 Tags and targets need not be cleared on reset.

Structure
REQ-031 ADDR_W default, RESET_VEC default, instruction stride (4) and counter encoding constants SHALL reside in the shared defines package.
REQ-032 BTB storage, lookup and update logic SHALL be one sub-module, pc_btb; pc_gen holds the pc register and next-pc mux.

Verification
REQ-033 Reset then 3 free-running cycles, no branches -> pc = 0, 4, 8, 12; pred_taken = 0 throughout.
REQ-034 Update upd_pc=0x10, taken, target 0x40; fetch reaches 0x10 -> pred_taken=1, next pc = 0x40.
REQ-035 Two not-taken updates at 0x10 after REQ-034 -> counter 2'b00, fetch at 0x10 proceeds to 0x14.
REQ-036 stall=1 with ex_redirect=1, target 0x200 -> pc = 0x200 next cycle; stall=1 alone -> pc holds; rdy=0 -> pc and BTB hold.
REQ-037 BTB_DEPTH=16: taken update at 0x10, then taken update at 0x50 (same index) -> fetch at 0x10 no prediction, fetch at 0x50 predicts.
REQ-038 ADDR_W=32, pc=0xFFFFFFFC, no prediction -> pc wraps to 0x0; rst asserted same cycle as update -> BTB stays empty.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch PC generator: address defaults, fetch stride
// and the 2-bit branch counter encoding with its saturating helpers.
package pc_gen_pkg;

  localparam int          ADDR_W_DEF    = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0;
  localparam int          PC_STRIDE     = 4;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? c : c + 2'd1;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch pc and
// a registered update from resolved branches. Lookup sees pre-update contents.
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic [ADDR_W-1:0] i_lkp_pc,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target,
  output logic              o_pred_taken,
  output logic [ADDR_W-1:0] o_pred_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  if (BTB_DEPTH < 2 || (1 << IDX_W) != BTB_DEPTH) begin : g_depth_chk
    $error("pc_btb: BTB_DEPTH must be a power of two and at least 2");
  end

  logic              r_valid  [BTB_DEPTH];
  ctr_t              r_ctr    [BTB_DEPTH];
  logic [TAG_W-1:0]  r_tag    [BTB_DEPTH];
  logic [ADDR_W-1:0] r_target [BTB_DEPTH];

  logic [IDX_W-1:0]  w_lkp_idx;
  logic [TAG_W-1:0]  w_lkp_tag;
  logic              w_lkp_hit;
  logic [IDX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_hit;
  logic              w_upd_en;
  logic              w_unused;

  assign w_lkp_idx = i_lkp_pc[IDX_W+1:2];
  assign w_lkp_tag = i_lkp_pc[ADDR_W-1:IDX_W+2];
  assign w_upd_idx = i_upd_pc[IDX_W+1:2];
  assign w_upd_tag = i_upd_pc[ADDR_W-1:IDX_W+2];
  // Byte-offset bits never participate in indexing or tagging.
  assign w_unused  = &{1'b0, i_lkp_pc[1:0], i_upd_pc[1:0]};

  assign w_lkp_hit     = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
  assign o_pred_taken  = w_lkp_hit && r_ctr[w_lkp_idx][1];
  assign o_pred_target = o_pred_taken ? r_target[w_lkp_idx] : '0;

  assign w_upd_en  = i_upd_valid && i_rdy && !rst;
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Control state: valid bits and counters are cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_SNT;
      end
    end else if (w_upd_en) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= i_upd_taken ? ctr_inc(r_ctr[w_upd_idx])
                                        : ctr_dec(r_ctr[w_upd_idx]);
      end else if (i_upd_taken) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_ctr[w_upd_idx]   <= CTR_WT;
      end
    end
  end

  // Tag and target payload; rewriting the tag on a hit is harmless.
  always_ff @(posedge clk) begin
    if (w_upd_en && i_upd_taken) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= i_upd_target;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter with next-pc selection between reset, execute redirect,
// stall hold, BTB prediction and sequential fetch.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter int              BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              stall,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic [ADDR_W-1:0] pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;

  pc_btb #(
    .ADDR_W   (ADDR_W),
    .BTB_DEPTH(BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .i_rdy        (rdy),
    .i_lkp_pc     (r_pc),
    .i_upd_valid  (upd_valid),
    .i_upd_pc     (upd_pc),
    .i_upd_taken  (upd_taken),
    .i_upd_target (upd_target),
    .o_pred_taken (w_pred_taken),
    .o_pred_target(w_pred_target)
  );

  // Redirect outranks stall so a mispredict is never lost behind a fetch stall.
  always_comb begin
    w_pc_next = r_pc;
    if (ex_redirect) begin
      w_pc_next = ex_target;
    end else if (!stall) begin
      w_pc_next = w_pred_taken ? w_pred_target : r_pc + ADDR_W'(PC_STRIDE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_VEC;
    end else if (rdy) begin
      r_pc <= w_pc_next;
    end
  end

  assign pc          = r_pc;
  assign pred_taken  = w_pred_taken;
  assign pred_target = w_pred_target;

endmodule
